serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operands and borrow-in are valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a new operation.
REQ-006 SHALL have port: a  input  WIDTH  minuend.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: out_valid  output  1  result is valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: diff  output  WIDTH  result of a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port: bout  output  1  unsigned borrow-out; 1 iff a < b + bin.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL hold in_ready high only in IDLE; out_valid high only in DONE.
REQ-015 SHALL, in IDLE on in_valid && in_ready at a clock edge, latch a, b and bin into internal shift/borrow registers, clear the bit counter and go to BUSY.
REQ-016 SHALL, in BUSY, process exactly one bit per cycle, starting at the LSB.
REQ-017 SHALL compute each bit from the current operand bits and the borrow register as follows: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-018 SHALL shift d into the diff register at the MSB end, so that diff is LSB-aligned after WIDTH shifts.
REQ-019 SHALL move from BUSY to DONE on the edge that processes bit WIDTH-1.
REQ-020 SHALL therefore assert out_valid exactly WIDTH cycles after the accepting edge.
REQ-021 SHALL present bout equal to the final borrow register in DONE.
REQ-022 SHALL hold diff, bout and out_valid stable in DONE until out_valid && out_ready; on that edge it returns to IDLE.
REQ-023 SHALL ignore in_valid and input-bus changes while in BUSY or DONE.
REQ-024 SHALL NOT combinationally couple in_ready and out_ready; back-to-back operations need one IDLE cycle.
REQ-025 SHALL handle the boundaries exactly: a == b with bin = 1 gives all-ones diff and bout = 1; 0 - 0 - 0 gives diff 0 and bout 0; the bit counter never wraps past WIDTH-1.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-BUSY, immediately force the FSM to IDLE.
REQ-027 SHALL, on reset, clear the shift registers, borrow register and counter to 0.
REQ-028 SHALL hold these output values during reset: in_ready = 0, out_valid = 0, diff = 0, bout = 0 (and ovf = 0 when present).
REQ-029 SHALL raise in_ready on the first clock edge after rst_n deasserts, and abandon any aborted operation without producing output.

Configuration
REQ-030 SHALL, when SERIAL_SUBTRACTOR_OVF_EN is defined, add port ovf (output, 1 bit): two's-complement overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched a and b, valid and held in DONE.
REQ-031 SHALL, when SERIAL_SUBTRACTOR_OVF_EN is undefined, have no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2) and the default WIDTH constant in shared package serial_subtractor_pkg.
REQ-033 SHALL instantiate exactly one combinational sub-module, full_subtractor (inputs in1, in2, bin; outputs diff, bout), for the per-bit datapath.
REQ-034 SHALL size the counter as $clog2(WIDTH) bits.

Verification (WIDTH = 4)
REQ-035 SHALL cover: a = 9, b = 3, bin = 0 -> diff = 6, bout = 0, out_valid exactly 4 cycles after accept.
REQ-036 SHALL cover: a = 3, b = 9, bin = 0 -> diff = 0xA, bout = 1; and a = 5, b = 5, bin = 1 -> diff = 0xF, bout = 1.
REQ-037 SHALL cover: with OVF_EN, a = 8, b = 1, bin = 0 -> diff = 7, ovf = 1; and a = 2, b = 1 -> diff = 1, ovf = 0.
REQ-038 SHALL cover: out_ready held low 6 cycles in DONE -> diff, bout and out_valid unchanged, in_ready = 0, and in_valid pulses ignored.
REQ-039 SHALL cover: rst_n pulsed low during bit 2 of a = 12, b = 4 -> out_valid never rises; in_ready = 1 one edge after release; then a = 12, b = 4 -> diff = 8, bout = 0.
REQ-040 SHALL cover: back-to-back operations with out_ready tied high -> each result correct, one IDLE cycle between out_valid and the next accept.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = in1 - in2 - bin, with unsigned borrow-out.
module full_subtractor (
   input  logic in1,
   input  logic in2,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = in1 ^ in2 ^ bin;
   assign bout = (~in1 & in2) | (~(in1 ^ in2) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per cycle LSB first, with a valid/ready handshake on each side.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic [CW-1:0]    cnt_q;
   logic             br_q;
   logic             rdy_q;
   logic             bit_d, br_d;
   logic             accept;

   assign accept = in_valid && in_ready;

   // in_ready stays low until the first edge after reset release.
   // NOTE: state/datapath registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q   <= 1'b0;
         state_q <= IDLE;
      end else begin
         rdy_q   <= 1'b1;
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets its default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = BUSY;
         BUSY:    if (cnt_q == LAST) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   full_subtractor u_fs (
      .in1  (a_q[0]),
      .in2  (b_q[0]),
      .bin  (br_q),
      .diff (bit_d),
      .bout (br_d)
   );

   // Operands rotate rather than shift, so after WIDTH steps they are back in
   // their latched positions and the original sign bits remain available in DONE.
   // NOTE: only a handful of flops, so all datapath registers get the async clear too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         diff_q <= '0;
         br_q   <= 1'b0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               a_q    <= a;
               b_q    <= b;
               br_q   <= bin;
               diff_q <= '0;
               cnt_q  <= '0;
            end
            BUSY: begin
               a_q    <= {a_q[0], a_q[WIDTH-1:1]};
               b_q    <= {b_q[0], b_q[WIDTH-1:1]};
               diff_q <= {bit_d, diff_q[WIDTH-1:1]};
               br_q   <= br_d;
               if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE) && rdy_q;
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = br_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf = out_valid && (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4): directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer subtraction modulo 2^W; overflow from the sign rule on a, b and diff.
   task automatic check_result(input string tag, input int ea, input int eb, input int ebin);
      int          r;
      logic [31:0] r32;
      logic [W-1:0] ed;
      logic        eb_out;
      r      = ea - eb - ebin;
      r32    = r;
      ed     = r32[W-1:0];
      eb_out = (ea < eb + ebin);
      check({tag, "_diff"}, 32'(diff), 32'(ed));
      check({tag, "_bout"}, 32'(bout), 32'(eb_out));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      begin
         int sa, sb, sd;
         sa = (ea >> (W - 1)) & 1;
         sb = (eb >> (W - 1)) & 1;
         sd = (int'(ed) >> (W - 1)) & 1;
         check({tag, "_ovf"}, 32'(ovf), 32'((sa != sb) && (sd != sa)));
      end
`endif
   endtask

   // Accept one operation, check latency and result, hold DONE for `hold` cycles with
   // in_valid noise, then release it and confirm the return to IDLE.
   task automatic do_op(input string tag, input int oa, input int ob, input int obin, input int hold);
      int waited = 0;
      int cycles = 0;
      while (!in_ready && waited < 20) begin
         tick();
         waited++;
      end
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      a = W'(oa); b = W'(ob); bin = obin[0]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      do begin
         tick();
         cycles++;
      end while (!out_valid && cycles < 3 * W);
      check({tag, "_latency"}, 32'(cycles), 32'(W));
      check_result(tag, oa, ob, obin);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         tick();
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
         check_result({tag, "_hold"}, oa, ob, obin);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int ra, rb, rbin, cycles;

      // Reset values, then in_ready one edge after release.
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready_pre", 32'(in_ready), 32'd0);
      tick();
      check("rel_in_ready_post", 32'(in_ready), 32'd1);

      // Directed corners.
      do_op("a9b3",  9, 3, 0, 0);
      do_op("a3b9",  3, 9, 0, 0);
      do_op("a5b5",  5, 5, 1, 0);
      do_op("zero",  0, 0, 0, 0);
      do_op("a8b1",  8, 1, 0, 0);
      do_op("a2b1",  2, 1, 0, 0);
      do_op("aFbF",  15, 15, 1, 0);
      do_op("a0bF",  0, 15, 1, 0);
      do_op("hold6", 9, 3, 0, 6);

      // Reset while bit 2 is being processed.
      a = W'(12); b = W'(4); bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      tick();
      tick();
      check("abort_hold_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("abort_rel_pre", 32'(in_ready), 32'd0);
      tick();
      check("abort_rel_post", 32'(in_ready), 32'd1);
      cycles = 0;
      for (int i = 0; i < W + 2; i++) begin
         tick();
         if (out_valid) cycles++;
      end
      check("abort_no_output", 32'(cycles), 32'd0);
      do_op("a12b4", 12, 4, 0, 0);

      // Random operands with random DONE hold times.
      for (int i = 0; i < 24; i++) begin
         do_op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // Back-to-back with out_ready tied high: exactly one IDLE cycle between results.
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         check("b2b_idle_ready", 32'(in_ready), 32'd1);
         check("b2b_idle_valid", 32'(out_valid), 32'd0);
         ra = int'($urandom_range(0, 15));
         rb = int'($urandom_range(0, 15));
         rbin = int'($urandom_range(0, 1));
         a = W'(ra); b = W'(rb); bin = rbin[0]; in_valid = 1'b1;
         tick();
         a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         cycles = 0;
         do begin
            tick();
            cycles++;
         end while (!out_valid && cycles < 3 * W);
         check("b2b_latency", 32'(cycles), 32'(W));
         check_result("b2b", ra, rb, rbin);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_serial_subtractor
